// File: rtl/fp16_acc.sv
// fp16_add: combinational IEEE half-precision adder, round-to-nearest-even, subnormal aware.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; its result is sampled by the enclosing block.
module fp16_add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        ovf,
    output logic        nan,
    output logic        plost
);

    function automatic logic [3:0] lzc14(input logic [13:0] v);
        logic [3:0] r;
        r = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (v[i]) r = 4'(13 - i);
        end
        return r;
    endfunction

    logic [15:0] x, y;
    logic [4:0]  ex, ey, d, dsh, sh;
    logic [10:0] mx, my;
    logic [26:0] y_full;
    logic [13:0] x_al, y_al, n;
    logic [14:0] sum15;
    logic        eff_sub, round_up, inexact;
    logic [3:0]  lz;
    logic [5:0]  en, exp_field;
    logic [15:0] val;
    logic        a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        a_inf = (a[14:0] == 15'h7C00);
        b_inf = (b[14:0] == 15'h7C00);

        // Order operands by magnitude so the aligned difference is never negative.
        x = a;
        y = b;
        if (b[14:0] > a[14:0]) begin
            x = b;
            y = a;
        end
        ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
        mx = {|x[14:10], x[9:0]};
        my = {|y[14:10], y[9:0]};
        d   = ex - ey;
        dsh = (d > 5'd27) ? 5'd27 : d;

        // Aligned mantissas carry guard, round and sticky bits below the LSB.
        y_full = {my, 16'd0} >> dsh;
        y_al   = {y_full[26:14], |y_full[13:0]};
        x_al   = {mx, 3'b000};
        eff_sub = x[15] ^ y[15];
        sum15 = eff_sub ? ({1'b0, x_al} - {1'b0, y_al}) : ({1'b0, x_al} + {1'b0, y_al});

        lz = lzc14(sum15[13:0]);
        sh = 5'd0;
        if (sum15[14]) begin
            n  = {sum15[14:2], sum15[1] | sum15[0]};
            en = {1'b0, ex} + 6'd1;
        end else begin
            sh = ({1'b0, lz} < ex) ? {1'b0, lz} : (ex - 5'd1);
            n  = sum15[13:0] << sh;
            en = {1'b0, ex} - {1'b0, sh};
        end
        exp_field = n[13] ? en : 6'd0;
        inexact   = n[2] | n[1] | n[0];
        round_up  = n[2] & (n[1] | n[0] | n[3]);
        // Exponent and fraction added as one field so a rounding carry bumps the exponent.
        val = {exp_field, n[12:3]} + {15'd0, round_up};

        sum   = {(sum15 == 15'd0) ? (x[15] & ~eff_sub) : x[15], val[14:0]};
        ovf   = 1'b0;
        nan   = 1'b0;
        plost = inexact;
        if (val[15:10] >= 6'd31) begin
            sum   = {x[15], 15'h7C00};
            ovf   = 1'b1;
            plost = 1'b1;
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
            sum   = 16'h7E00;
            nan   = 1'b1;
            ovf   = 1'b0;
            plost = 1'b0;
        end else if (a_inf || b_inf) begin
            sum   = a_inf ? a : b;
            ovf   = 1'b1;
            plost = 1'b0;
        end
    end

endmodule

// fp16_acc: reduces a group of FP16 elements to one FP16 sum with sticky status flags.
// Latency: result presented 1 cycle after the last-element accept; one element per cycle.
// Backpressure: in_ready drops while a result is held until out_ready takes it.
module fp16_acc #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_nan,
    output logic             out_plost,
    output logic             out_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state;
    logic [15:0]      acc;
    logic [CNT_W-1:0] count;
    logic             ovf, nan, plost;
    logic [15:0]      add_sum;
    logic             add_ovf, add_nan, add_plost;
    logic             accept, in_nan, in_inf, hold;

    fp16_add u_add (
        .a     (acc),
        .b     (in_data),
        .sum   (add_sum),
        .ovf   (add_ovf),
        .nan   (add_nan),
        .plost (add_plost)
    );

    assign hold     = (state == HOLD);
    assign in_ready = !reset && !hold;
    assign accept   = in_valid && in_ready;
    assign in_nan   = (in_data[14:10] == 5'h1F) && (in_data[9:0] != 10'd0);
    assign in_inf   = (in_data[14:0] == 15'h7C00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= 16'd0;
            count <= '0;
            ovf   <= 1'b0;
            nan   <= 1'b0;
            plost <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        if (state == IDLE) begin
                            // First element of a group loads directly; no add against stale acc.
                            acc   <= in_data;
                            count <= {{(CNT_W-1){1'b0}}, 1'b1};
                            ovf   <= in_inf;
                            nan   <= in_nan;
                            plost <= 1'b0;
                        end else begin
                            acc   <= add_sum;
                            if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
                            ovf   <= ovf | add_ovf;
                            nan   <= nan | add_nan;
                            plost <= plost | add_plost;
                        end
                        state <= in_last ? HOLD : ACC;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                        acc   <= 16'd0;
                        count <= '0;
                        ovf   <= 1'b0;
                        nan   <= 1'b0;
                        plost <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = hold;
    assign out_data  = hold ? acc : 16'd0;
    assign out_count = hold ? count : '0;
    assign out_ovf   = hold & ovf;
    assign out_nan   = hold & nan;
    assign out_plost = hold & plost;
    assign out_zero  = hold & (acc[14:0] == 15'd0);

endmodule

// File: tb/tb_fp16_acc.sv
// Directed bench for fp16_acc: vector table of reduction groups plus handshake/reset sequences.
module tb_fp16_acc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_count;
    logic        out_ovf, out_nan, out_plost, out_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp16_acc #(.CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_nan   (out_nan),
        .out_plost (out_plost),
        .out_zero  (out_zero)
    );

    typedef struct {
        int          n;
        logic [15:0] e [3];
        logic [15:0] data;
        int          cnt;
        logic        ovf, nan, plost, zero;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(int n, logic [15:0] e0, logic [15:0] e1, logic [15:0] e2,
                                logic [15:0] d, int c, logic ov, logic na, logic pl, logic z);
        vec_t v;
        v.n = n; v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
        v.data = d; v.cnt = c; v.ovf = ov; v.nan = na; v.plost = pl; v.zero = z;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] d, input logic last, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " rel out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " rel out_data"}, {16'd0, out_data}, 32'd0);
        chk({tag, " rel out_count"}, {24'd0, out_count}, 32'd0);
        chk({tag, " rel in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] d, input int c,
                                input logic ov, input logic na, input logic pl, input logic z);
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, " out_data"}, {16'd0, out_data}, {16'd0, d});
        chk({tag, " out_count"}, {24'd0, out_count}, c);
        chk({tag, " out_ovf"}, {31'd0, out_ovf}, {31'd0, ov});
        chk({tag, " out_nan"}, {31'd0, out_nan}, {31'd0, na});
        chk({tag, " out_plost"}, {31'd0, out_plost}, {31'd0, pl});
        chk({tag, " out_zero"}, {31'd0, out_zero}, {31'd0, z});
    endtask

    initial begin
        vecs[0]  = mk(2, 16'h3C00, 16'h3C00, 16'h0000, 16'h4000, 2, 0, 0, 0, 0); // 1+1
        vecs[1]  = mk(1, 16'hC500, 16'h0000, 16'h0000, 16'hC500, 1, 0, 0, 0, 0); // single
        vecs[2]  = mk(2, 16'h3C00, 16'hBC00, 16'h0000, 16'h0000, 2, 0, 0, 0, 1); // cancel
        vecs[3]  = mk(2, 16'h7BFF, 16'h7BFF, 16'h0000, 16'h7C00, 2, 1, 0, 1, 0); // overflow
        vecs[4]  = mk(3, 16'h3C00, 16'h3C00, 16'h4000, 16'h4400, 3, 0, 0, 0, 0); // 1+1+2
        vecs[5]  = mk(2, 16'h3C00, 16'h1400, 16'h0000, 16'h3C01, 2, 0, 0, 0, 0); // 1+2^-10
        vecs[6]  = mk(2, 16'h3C00, 16'h0C00, 16'h0000, 16'h3C00, 2, 0, 0, 1, 0); // 1+2^-12
        vecs[7]  = mk(2, 16'h7C00, 16'h3C00, 16'h0000, 16'h7C00, 2, 1, 0, 0, 0); // inf+1
        vecs[8]  = mk(2, 16'h7C00, 16'hFC00, 16'h0000, 16'h7E00, 2, 1, 1, 0, 0); // inf-inf
        vecs[9]  = mk(2, 16'h0001, 16'h0001, 16'h0000, 16'h0002, 2, 0, 0, 0, 0); // subnormals
        vecs[10] = mk(2, 16'h3C00, 16'h3C01, 16'h0000, 16'h4000, 2, 0, 0, 1, 0); // RNE tie

        reset = 1'b1; in_valid = 1'b0; in_data = 16'd0; in_last = 1'b0; out_ready = 1'b0;
        step();
        chk("reset in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("post-reset out_data", {16'd0, out_data}, 32'd0);
        chk("post-reset out_count", {24'd0, out_count}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            for (int k = 0; k < vecs[i].n; k++)
                feed(vecs[i].e[k], (k == vecs[i].n - 1), tag);
            check_result(tag, vecs[i].data, vecs[i].cnt, vecs[i].ovf, vecs[i].nan,
                         vecs[i].plost, vecs[i].zero);
            release_result(tag);
        end

        // Held result stays frozen while downstream stalls and upstream keeps pushing.
        feed(16'h3C00, 1'b0, "hold");
        feed(16'h3C00, 1'b1, "hold");
        in_valid = 1'b1; in_data = 16'h4000; in_last = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("hold out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold out_data", {16'd0, out_data}, 32'h4000);
            chk("hold out_count", {24'd0, out_count}, 32'd2);
            chk("hold in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("hold drained out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold drained in_ready", {31'd0, in_ready}, 32'd1);
        feed(16'hC500, 1'b1, "after-hold");
        check_result("after-hold", 16'hC500, 1, 0, 0, 0, 0);
        release_result("after-hold");

        // Reset mid-group drops the partial sum.
        for (int k = 0; k < 3; k++) feed(16'h3C00, 1'b0, "rst-mid");
        reset = 1'b1; in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b1;
        #1;
        chk("rst-mid in_ready", {31'd0, in_ready}, 32'd0);
        step();
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("rst-mid out_valid", {31'd0, out_valid}, 32'd0);
        feed(16'h4000, 1'b1, "rst-mid");
        check_result("rst-mid", 16'h4000, 1, 0, 0, 0, 0);
        release_result("rst-mid");

        // Reset in HOLD wins over out_ready and in_valid; the pending result vanishes.
        feed(16'h3C00, 1'b1, "rst-hold");
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h4000; in_last = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rst-hold out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst-hold out_data", {16'd0, out_data}, 32'd0);
            step();
        end

        // Count saturates at 255 while accumulation continues.
        for (int k = 0; k < 299; k++) feed(16'h0000, 1'b0, "sat");
        feed(16'h3C00, 1'b1, "sat");
        check_result("sat", 16'h3C00, 255, 0, 0, 0, 0);
        release_result("sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/fp16_acc.md
FP16_ACC -- requirements
Module: fp16_acc

Interface
REQ-001 CNT_W, 8, width of element counter; count saturates at 2^CNT_W-1.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 in_valid  input  1  upstream element (FP16 product) valid.
REQ-005 in_ready  output  1  block can accept an element this cycle.
REQ-006 in_data  input  16  FP16 element (1 sign, 5 exp, 10 frac).
REQ-007 in_last  input  1  element is final of current reduction group.
REQ-008 out_valid  output  1  reduced group result available.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_data  output  16  FP16 group sum.
REQ-011 out_count  output  CNT_W  elements accepted in group, saturating.
REQ-012 out_ovf / out_nan / out_plost / out_zero  output  1 each  sticky overflow, NaN, precision-lost flags; result-is-zero flag.

Function
REQ-013 Block SHALL instantiate the team's combinational FP16 adder once; operands acc and in_data; sustained rate one element per cycle.
REQ-014 States SHALL be IDLE (no element in group), ACC (>=1 element accumulated), HOLD (result presented).
REQ-015 in_ready SHALL be 1 in IDLE and ACC, 0 in HOLD; accept = in_valid & in_ready.
REQ-016 IDLE accept: acc <= in_data directly (no add); count <= 1; nan <= in_data is NaN; ovf <= in_data is +/-inf; plost <= 0.
REQ-017 ACC accept: acc <= adder result; count <= count+1 saturating; ovf/nan/plost OR-ed with adder flags.
REQ-018 Accept with in_last=0: next state ACC; with in_last=1: next state HOLD.
REQ-019 out_valid SHALL be 1 exactly in HOLD, i.e. first asserted the cycle after the last-element accept (latency 1 cycle).
REQ-020 In HOLD out_data=acc, out_count=count, flags=sticky values, out_zero=(acc[14:0]==0); all SHALL stay stable until out_ready.
REQ-021 HOLD & out_ready: acc, count, flags cleared to 0; next state IDLE; no input accepted in that cycle.
REQ-022 in_valid while in_ready=0 SHALL be ignored; in_data/in_last unsampled.
REQ-023 acc SHALL take adder result unmodified, including 0x7C00 on overflow and NaN patterns; no further rounding.
REQ-024 count at 2^CNT_W-1 SHALL hold; accumulation continues normally.
REQ-025 out_data/out_count/flags SHALL read 0 when out_valid=0.

Reset
REQ-026 reset SHALL force IDLE, acc=0, count=0, all flags 0, out_valid=0, in_ready=0 during reset cycle, 1 the cycle after.
REQ-027 reset mid-group or in HOLD SHALL discard partial/pending result; no out_valid produced for it.
REQ-028 reset SHALL override simultaneous in_valid and out_ready.

Verification
REQ-029 0x3C00, then 0x3C00 with last -> next cycle out_valid=1, out_data=0x4000, out_count=2, flags 0.
REQ-030 Single 0xC500 with last from IDLE -> out_data=0xC500, out_count=1, out_zero=0.
REQ-031 0x3C00, then 0xBC00 with last -> out_data=0x0000, out_zero=1, out_ovf=0.
REQ-032 0x7BFF, then 0x7BFF with last -> out_data=0x7C00, out_ovf=1.
REQ-033 Result pending, out_ready=0 for 5 cycles with in_valid=1 -> out_valid and outputs stable, in_ready=0, no input accepted; out_ready=1 -> IDLE next cycle.
REQ-034 Reset asserted after 3 accepted elements (no last), then 0x4000 with last -> out_data=0x4000, out_count=1.
